// File: rtl/im_decompression.sv
// im_decompression: nearest-neighbour upscaler that re-reads each source row pSCALE_Y times
// and writes every source pixel as pSCALE_X consecutive output pixels.
module im_decompression #(
    parameter int pIN_IM_WIDTH  = 160,
    parameter int pIN_IM_HEIGHT = 120,
    parameter int pSCALE_X      = 4,
    parameter int pSCALE_Y      = 4,
    parameter int pDATA_W       = 24,
    localparam int lpOUT_W  = pIN_IM_WIDTH * pSCALE_X,
    localparam int lpC2_IN  = $clog2(pIN_IM_WIDTH * pIN_IM_HEIGHT),
    localparam int lpC2_OUT = $clog2(lpOUT_W * pIN_IM_HEIGHT * pSCALE_Y)
) (
    input  logic                iclk,
    input  logic                irst,
    input  logic [pDATA_W-1:0]  idata_rd,
    output logic [lpC2_IN-1:0]  oaddr_rd,
    output logic                omem_rd_en,
    output logic [pDATA_W-1:0]  odata_wr,
    output logic [lpC2_OUT-1:0] oaddr_wr,
    output logic                omem_wr_en,
    input  logic                iwr_ready,
    input  logic [lpC2_IN-1:0]  ird_base_ptr,
    input  logic [lpC2_OUT-1:0] iwr_base_ptr,
    input  logic                istart_work,
    output logic                omodule_work_f,
    output logic                omodule_done_f
);
    localparam int lpXW = pIN_IM_WIDTH > 1 ? $clog2(pIN_IM_WIDTH) : 1;
    localparam int lpYW = pIN_IM_HEIGHT > 1 ? $clog2(pIN_IM_HEIGHT) : 1;
    localparam int lpKW = pSCALE_X > 1 ? $clog2(pSCALE_X) : 1;
    localparam int lpRW = pSCALE_Y > 1 ? $clog2(pSCALE_Y) : 1;
    localparam logic [lpC2_IN-1:0]  lpRD_STEP = lpC2_IN'(pIN_IM_WIDTH);
    localparam logic [lpC2_OUT-1:0] lpWR_STEP = lpC2_OUT'(lpOUT_W);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_WR     = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]          state;
    logic [lpXW-1:0]     src_x;
    logic [lpYW-1:0]     src_y;
    logic [lpRW-1:0]     rep_y;
    logic [lpKW-1:0]     k;
    logic [lpC2_IN-1:0]  rd_row, rd_addr;
    logic [lpC2_OUT-1:0] wr_row, wr_addr;
    logic [pDATA_W-1:0]  pixel;
    logic                last_k, last_x, last_rep, last_y;

    assign last_k   = k == lpKW'(pSCALE_X - 1);
    assign last_x   = src_x == lpXW'(pIN_IM_WIDTH - 1);
    assign last_rep = rep_y == lpRW'(pSCALE_Y - 1);
    assign last_y   = src_y == lpYW'(pIN_IM_HEIGHT - 1);

    assign omem_rd_en     = state == S_RD;
    assign omem_wr_en     = state == S_WR;
    assign omodule_work_f = state == S_RD || state == S_LATCH || state == S_WR;
    assign omodule_done_f = state == S_FINISH;
    assign oaddr_rd       = rd_addr;
    assign oaddr_wr       = wr_addr;
    assign odata_wr       = pixel;

    // rd_row/wr_row hold the first address of the current source/output row,
    // so every address is reached by adding a constant step instead of multiplying.
    always_ff @(posedge iclk) begin
        if (!irst) begin
            state   <= S_IDLE;
            src_x   <= '0;
            src_y   <= '0;
            rep_y   <= '0;
            k       <= '0;
            rd_row  <= '0;
            rd_addr <= '0;
            wr_row  <= '0;
            wr_addr <= '0;
            pixel   <= '0;
        end else begin
            case (state)
                S_IDLE: if (istart_work) begin
                    rd_row  <= ird_base_ptr;
                    rd_addr <= ird_base_ptr;
                    wr_row  <= iwr_base_ptr;
                    wr_addr <= iwr_base_ptr;
                    src_x   <= '0;
                    src_y   <= '0;
                    rep_y   <= '0;
                    k       <= '0;
                    state   <= S_RD;
                end
                S_RD: state <= S_LATCH;
                S_LATCH: begin
                    pixel <= idata_rd;
                    state <= S_WR;
                end
                S_WR: if (iwr_ready) begin
                    k       <= last_k ? '0 : k + lpKW'(1);
                    wr_addr <= wr_addr + lpC2_OUT'(1);
                    if (last_k) begin
                        src_x <= last_x ? '0 : src_x + lpXW'(1);
                        state <= S_RD;
                        if (!last_x) begin
                            rd_addr <= rd_addr + lpC2_IN'(1);
                        end else begin
                            wr_row  <= wr_row + lpWR_STEP;
                            wr_addr <= wr_row + lpWR_STEP;
                            rep_y   <= last_rep ? '0 : rep_y + lpRW'(1);
                            if (!last_rep) begin
                                rd_addr <= rd_row;
                            end else begin
                                rd_row  <= rd_row + lpRD_STEP;
                                rd_addr <= rd_row + lpRD_STEP;
                                src_y   <= last_y ? '0 : src_y + lpYW'(1);
                                state   <= last_y ? S_FINISH : S_RD;
                            end
                        end
                    end
                end
                S_FINISH: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_im_decompression.sv
// tb_im_decompression: random frames on a small asymmetric geometry, checked against
// an output-pixel-indexed reference (each output pixel maps back to its source pixel).
module tb_im_decompression;
    localparam int IW = 3, IH = 2, SX = 2, SY = 3, DW = 24;
    localparam int OW = IW * SX, OH = IH * SY;
    localparam int AIN = $clog2(IW * IH), AOUT = $clog2(OW * OH);
    localparam int PIX_CYC = IW * IH * SY * (2 + SX);

    logic            clk = 0;
    logic            rst_n = 0;
    logic [DW-1:0]   idata_rd = '0;
    logic [AIN-1:0]  oaddr_rd;
    logic            omem_rd_en;
    logic [DW-1:0]   odata_wr;
    logic [AOUT-1:0] oaddr_wr;
    logic            omem_wr_en;
    logic            iwr_ready = 1;
    logic [AIN-1:0]  ird_base_ptr = '0;
    logic [AOUT-1:0] iwr_base_ptr = '0;
    logic            istart_work = 0;
    logic            omodule_work_f, omodule_done_f;

    logic [DW-1:0] mem [0:(1<<AIN)-1];
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (omem_rd_en) idata_rd <= mem[oaddr_rd];

    im_decompression #(
        .pIN_IM_WIDTH(IW), .pIN_IM_HEIGHT(IH), .pSCALE_X(SX), .pSCALE_Y(SY), .pDATA_W(DW)
    ) dut (
        .iclk(clk), .irst(rst_n), .idata_rd(idata_rd), .oaddr_rd(oaddr_rd),
        .omem_rd_en(omem_rd_en), .odata_wr(odata_wr), .oaddr_wr(oaddr_wr),
        .omem_wr_en(omem_wr_en), .iwr_ready(iwr_ready), .ird_base_ptr(ird_base_ptr),
        .iwr_base_ptr(iwr_base_ptr), .istart_work(istart_work),
        .omodule_work_f(omodule_work_f), .omodule_done_f(omodule_done_f)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] all_outs();
        return {27'd0, oaddr_rd, omem_rd_en, odata_wr, oaddr_wr, omem_wr_en, omodule_work_f, omodule_done_f};
    endfunction

    // n-th write in raster order of the upscaled frame
    function automatic logic [AOUT-1:0] exp_addr(input int wb, input int n);
        int oy = n / OW, ox = n % OW;
        return AOUT'((wb + oy * OW + ox) % (1 << AOUT));
    endfunction

    function automatic logic [DW-1:0] exp_data(input int rb, input int n);
        int oy = n / OW, ox = n % OW;
        return mem[(rb + (oy / SY) * IW + ox / SX) % (1 << AIN)];
    endfunction

    task automatic run_frame(input int rb, input int wb, input bit stall, input bit hold, input int abort_at);
        int n = 0, stalls = 0, cyc = 0;
        bit done = 0, pstall = 0;
        logic [AOUT-1:0] pa = '0;
        logic [DW-1:0] pd = '0;
        @(negedge clk);
        ird_base_ptr = AIN'(rb);
        iwr_base_ptr = AOUT'(wb);
        istart_work = 1;
        iwr_ready = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            istart_work = hold;
            if (hold) begin
                ird_base_ptr = AIN'($urandom);
                iwr_base_ptr = AOUT'($urandom);
            end
            iwr_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (pstall) chk("stall_hold", {oaddr_wr, odata_wr}, {pa, pd});
            if (omodule_done_f) begin
                done = 1;
                chk("done_cycle", cyc, 1 + PIX_CYC + stalls);
                chk("write_count", n, OW * OH);
                chk("finish_strobes", {omodule_work_f, omem_wr_en, omem_rd_en}, 0);
            end else begin
                chk("work_flag", omodule_work_f, 1);
                chk("strobe_excl", omem_rd_en & omem_wr_en, 0);
                if (omem_wr_en && iwr_ready) begin
                    chk("wr_addr", oaddr_wr, exp_addr(wb, n));
                    chk("wr_data", odata_wr, exp_data(rb, n));
                    n++;
                    if (n == abort_at) break;
                end
                if (omem_wr_en && !iwr_ready) stalls++;
            end
            pstall = omem_wr_en && !iwr_ready;
            pa = oaddr_wr;
            pd = odata_wr;
        end
        if (abort_at == 0) chk("frame_finished", done, 1);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < (1 << AIN); i++) mem[i] = DW'($urandom);
    endtask

    initial begin
        fill_mem();
        rst_n = 0;
        istart_work = 1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", all_outs(), 0);
        end
        istart_work = 0;
        rst_n = 1;
        @(negedge clk);
        chk("idle_after_reset", all_outs(), 0);

        run_frame(0, 0, 0, 0, 0);
        run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 63)), 1, 0, 0);
        fill_mem();
        run_frame(5, 50, 1, 1, 0);
        run_frame(2, 61, 0, 0, 0);

        run_frame(1, 9, 0, 0, 7);
        @(negedge clk);
        rst_n = 0;
        istart_work = 0;
        @(negedge clk);
        chk("midframe_reset", all_outs(), 0);
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("quiet_after_reset", {omem_rd_en, omem_wr_en, omodule_work_f, omodule_done_f}, 0);
        end
        run_frame(0, 37, 0, 0, 0);

        for (int f = 0; f < 4; f++) begin
            fill_mem();
            run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 63)), 1, f[0], 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
